// File: rtl/register_bank_streamer.sv
// Debug-path serializer: walks a register bank over [first, last] and hands one
// {prefix, stamp, index, value} frame per register to the UART writer.
module register_bank_streamer #(
  parameter int unsigned              UART_BUS_SIZE  = 8,
  parameter int unsigned              REGISTER_SIZE  = 32,
  parameter int unsigned              REGISTER_COUNT = 32,
  parameter int unsigned              PREFIX_SIZE    = 8,
  parameter logic [PREFIX_SIZE-1:0]   PREFIX         = 8'h52,
  localparam int unsigned             DATA_OUT_SIZE  = PREFIX_SIZE + 2*UART_BUS_SIZE + REGISTER_SIZE
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_start,
  input  logic                                    i_abort,
  input  logic                                    i_skip_zero,
  input  logic [UART_BUS_SIZE-1:0]                i_first,
  input  logic [UART_BUS_SIZE-1:0]                i_last,
  input  logic [REGISTER_COUNT*REGISTER_SIZE-1:0] i_registers,
  input  logic [UART_BUS_SIZE-1:0]                i_clk_cicle,
  input  logic                                    i_wr_end,
  output logic                                    o_start_wr,
  output logic [DATA_OUT_SIZE-1:0]                o_data_wr,
  output logic                                    o_busy,
  output logic                                    o_end,
  output logic                                    o_aborted,
  output logic [UART_BUS_SIZE:0]                  o_count
);

  // Index is one bit wider than the bus so last = 2**UART_BUS_SIZE-1 cannot wrap.
  localparam int unsigned            IW        = UART_BUS_SIZE + 1;
  localparam logic [IW-1:0]          IDX_ONE   = IW'(1);
  localparam logic [IW-1:0]          REG_COUNT = IW'(REGISTER_COUNT);
  localparam logic [IW-1:0]          LAST_MAX  = IW'(REGISTER_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StScan, StGuard, StWait} state_t;

  state_t                     r_state, w_state_next;
  logic [IW-1:0]              r_idx, w_idx_next;
  logic [IW-1:0]              r_last, w_last_next;
  logic                       r_skip, w_skip_next;
  logic [UART_BUS_SIZE-1:0]   r_stamp, w_stamp_next;
  logic [DATA_OUT_SIZE-1:0]   r_data, w_data_next;
  logic                       r_start_wr, w_start_wr_next;
  logic                       r_end, w_end_next;
  logic                       r_aborted, w_aborted_next;
  logic [IW-1:0]              r_count, w_count_next;

  logic [REGISTER_SIZE-1:0]   w_reg_val;
  logic                       w_scan_done;
  logic                       w_skip_reg;
  logic [IW-1:0]              w_first_ext;
  logic [IW-1:0]              w_last_ext;
  logic [IW-1:0]              w_last_clamped;

  // Live register read; out-of-range indices read as zero and are never emitted.
  always_comb begin
    w_reg_val = '0;
    for (int unsigned r = 0; r < REGISTER_COUNT; r++) begin
      if (r_idx == IW'(r)) begin
        w_reg_val = i_registers[r*REGISTER_SIZE +: REGISTER_SIZE];
      end
    end
  end

  assign w_scan_done    = (r_idx > r_last) || (r_idx >= REG_COUNT);
  assign w_skip_reg     = r_skip && (w_reg_val == '0);
  assign w_first_ext    = {1'b0, i_first};
  assign w_last_ext     = {1'b0, i_last};
  assign w_last_clamped = (w_last_ext > LAST_MAX) ? LAST_MAX : w_last_ext;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_last     <= '0;
      r_skip     <= 1'b0;
      r_stamp    <= '0;
      r_data     <= '0;
      r_start_wr <= 1'b0;
      r_end      <= 1'b0;
      r_aborted  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_last     <= w_last_next;
      r_skip     <= w_skip_next;
      r_stamp    <= w_stamp_next;
      r_data     <= w_data_next;
      r_start_wr <= w_start_wr_next;
      r_end      <= w_end_next;
      r_aborted  <= w_aborted_next;
      r_count    <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StScan;
      end
      StScan: begin
        if (i_abort || w_scan_done) w_state_next = StIdle;
        else if (!w_skip_reg)       w_state_next = StGuard;
      end
      // wr_end is deliberately ignored here so a stale pulse cannot advance the walk.
      StGuard: begin
        w_state_next = i_abort ? StIdle : StWait;
      end
      StWait: begin
        if (i_abort)       w_state_next = StIdle;
        else if (i_wr_end) w_state_next = StScan;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_idx_next      = r_idx;
    w_last_next     = r_last;
    w_skip_next     = r_skip;
    w_stamp_next    = r_stamp;
    w_data_next     = r_data;
    w_start_wr_next = 1'b0;
    w_end_next      = r_end;
    w_aborted_next  = r_aborted;
    w_count_next    = r_count;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_idx_next     = w_first_ext;
          w_last_next    = w_last_clamped;
          w_skip_next    = i_skip_zero;
          w_stamp_next   = i_clk_cicle;
          w_end_next     = 1'b0;
          w_aborted_next = 1'b0;
          w_count_next   = '0;
        end
      end
      StScan: begin
        if (i_abort) begin
          w_end_next     = 1'b1;
          w_aborted_next = 1'b1;
        end else if (w_scan_done) begin
          w_end_next = 1'b1;
        end else if (w_skip_reg) begin
          w_idx_next = r_idx + IDX_ONE;
        end else begin
          w_data_next     = {PREFIX, r_stamp, r_idx[UART_BUS_SIZE-1:0], w_reg_val};
          w_start_wr_next = 1'b1;
          w_count_next    = r_count + IDX_ONE;
          w_idx_next      = r_idx + IDX_ONE;
        end
      end
      StGuard, StWait: begin
        if (i_abort) begin
          w_end_next     = 1'b1;
          w_aborted_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_start_wr = r_start_wr;
  assign o_data_wr  = r_data;
  assign o_busy     = (r_state != StIdle);
  assign o_end      = r_end;
  assign o_aborted  = r_aborted;
  assign o_count    = r_count;

endmodule

// File: tb/tb_register_bank_streamer.sv
// Directed bench for register_bank_streamer with a simple UART-writer responder.
module tb_register_bank_streamer;

  localparam int RC = 32;
  localparam int RS = 32;
  localparam int DW = 56;

  logic           i_clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_start = 1'b0;
  logic           i_abort = 1'b0;
  logic           i_skip_zero = 1'b0;
  logic           i_wr_end = 1'b0;
  logic [7:0]     i_first = '0;
  logic [7:0]     i_last = '0;
  logic [7:0]     i_clk_cicle = '0;
  logic [RC*RS-1:0] i_registers = '0;
  logic           o_start_wr;
  logic [DW-1:0]  o_data_wr;
  logic           o_busy;
  logic           o_end;
  logic           o_aborted;
  logic [8:0]     o_count;

  int             n_checks = 0;
  int             n_fail = 0;
  longint         cyc_now = 0;
  longint         t0 = 0;
  logic [DW-1:0]  fr_data [64];
  longint         fr_t [64];
  int             nfr;
  int             bad;

  register_bank_streamer dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_skip_zero (i_skip_zero),
    .i_first     (i_first),
    .i_last      (i_last),
    .i_registers (i_registers),
    .i_clk_cicle (i_clk_cicle),
    .i_wr_end    (i_wr_end),
    .o_start_wr  (o_start_wr),
    .o_data_wr   (o_data_wr),
    .o_busy      (o_busy),
    .o_end       (o_end),
    .o_aborted   (o_aborted),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc_now <= cyc_now + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < RC; r++) i_registers[r*RS +: RS] = RS'(r + 1);
  endtask

  task automatic do_start(input logic [7:0] first, input logic [7:0] last, input logic skip,
                          input logic [7:0] stamp);
    i_first = first;
    i_last = last;
    i_skip_zero = skip;
    i_clk_cicle = stamp;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    t0 = cyc_now;
  endtask

  // Acts as the UART writer until o_end; abort_after=N aborts in WAIT after frame N.
  task automatic serve(input int abort_after, input bit hold_mode, output int n);
    int cyc;
    cyc = 0;
    n = 0;
    while (!o_end && cyc < 2000) begin
      if (o_start_wr) begin
        if (n < 64) begin
          fr_data[n] = o_data_wr;
          fr_t[n] = cyc_now;
        end
        n++;
        if (n == abort_after) begin
          tick();
          i_abort = 1'b1;
          tick();
          i_abort = 1'b0;
          cyc += 2;
        end else if (hold_mode) begin
          // wr_end already high while the DUT is in its guard cycle
          i_wr_end = 1'b1;
          tick();
          tick();
          i_wr_end = 1'b0;
          cyc += 2;
        end else begin
          tick();
          check_eq("pulse_width", {63'd0, o_start_wr}, 64'd0);
          tick();
          i_wr_end = 1'b1;
          tick();
          i_wr_end = 1'b0;
          cyc += 3;
        end
      end else begin
        tick();
        cyc++;
      end
    end
    if (cyc >= 2000) check_eq("serve_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    check_eq("rst_start_wr", {63'd0, o_start_wr}, 64'd0);
    check_eq("rst_data", 64'(o_data_wr), 64'd0);
    check_eq("rst_busy", {63'd0, o_busy}, 64'd0);
    check_eq("rst_end", {63'd0, o_end}, 64'd0);
    check_eq("rst_aborted", {63'd0, o_aborted}, 64'd0);
    check_eq("rst_count", 64'(o_count), 64'd0);

    // 1: full bank, ramp values
    fill_ramp();
    do_start(8'd0, 8'd31, 1'b0, 8'h07);
    check_eq("t1_busy", {63'd0, o_busy}, 64'd1);
    check_eq("t1_no_pulse_yet", {63'd0, o_start_wr}, 64'd0);
    serve(0, 1'b0, nfr);
    check_eq("t1_frames", 64'(nfr), 64'd32);
    check_eq("t1_latency", 64'(fr_t[0] - t0), 64'd1);
    check_eq("t1_gap", 64'(fr_t[1] - fr_t[0]), 64'd4);
    check_eq("t1_frame5", 64'(fr_data[5]), 64'({8'h52, 8'h07, 8'h05, 32'h6}));
    check_eq("t1_frame31", 64'(fr_data[31]), 64'({8'h52, 8'h07, 8'h1f, 32'h20}));
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (fr_data[k] !== {8'h52, 8'h07, 8'(k), 32'(k + 1)}) bad++;
    check_eq("t1_sequence", 64'(bad), 64'd0);
    check_eq("t1_count", 64'(o_count), 64'd32);
    check_eq("t1_end", {63'd0, o_end}, 64'd1);
    check_eq("t1_aborted", {63'd0, o_aborted}, 64'd0);
    check_eq("t1_idle", {63'd0, o_busy}, 64'd0);
    check_eq("t1_data_held", 64'(o_data_wr), 64'({8'h52, 8'h07, 8'h1f, 32'h20}));

    // 2: skip zeros
    i_registers = '0;
    i_registers[3*RS +: RS] = 32'hDEAD;
    i_registers[30*RS +: RS] = 32'h1;
    do_start(8'd0, 8'd31, 1'b1, 8'hA5);
    serve(0, 1'b0, nfr);
    check_eq("t2_frames", 64'(nfr), 64'd2);
    check_eq("t2_latency", 64'(fr_t[0] - t0), 64'd4);
    check_eq("t2_frame0", 64'(fr_data[0]), 64'({8'h52, 8'hA5, 8'h03, 32'hDEAD}));
    check_eq("t2_frame1", 64'(fr_data[1]), 64'({8'h52, 8'hA5, 8'h1e, 32'h1}));
    check_eq("t2_count", 64'(o_count), 64'd2);

    // 3: sub-range, empty range, clamped last
    fill_ramp();
    do_start(8'd10, 8'd12, 1'b0, 8'h3C);
    serve(0, 1'b0, nfr);
    check_eq("t3_frames", 64'(nfr), 64'd3);
    check_eq("t3_frame0", 64'(fr_data[0]), 64'({8'h52, 8'h3C, 8'h0a, 32'hb}));
    check_eq("t3_frame2", 64'(fr_data[2]), 64'({8'h52, 8'h3C, 8'h0c, 32'hd}));
    check_eq("t3_count", 64'(o_count), 64'd3);
    do_start(8'd5, 8'd4, 1'b0, 8'h00);
    check_eq("t3e_end_early", {63'd0, o_end}, 64'd0);
    check_eq("t3e_busy", {63'd0, o_busy}, 64'd1);
    tick();
    check_eq("t3e_end", {63'd0, o_end}, 64'd1);
    check_eq("t3e_idle", {63'd0, o_busy}, 64'd0);
    check_eq("t3e_no_pulse", {63'd0, o_start_wr}, 64'd0);
    check_eq("t3e_count", 64'(o_count), 64'd0);
    do_start(8'd30, 8'd255, 1'b0, 8'h44);
    serve(0, 1'b0, nfr);
    check_eq("t3c_frames", 64'(nfr), 64'd2);
    check_eq("t3c_frame1", 64'(fr_data[1]), 64'({8'h52, 8'h44, 8'h1f, 32'h20}));
    check_eq("t3c_end", {63'd0, o_end}, 64'd1);

    // 4: wr_end already high during the guard cycle
    do_start(8'd0, 8'd3, 1'b0, 8'h21);
    serve(0, 1'b1, nfr);
    check_eq("t4_frames", 64'(nfr), 64'd4);
    check_eq("t4_gap", 64'(fr_t[1] - fr_t[0]), 64'd3);
    check_eq("t4_frame3", 64'(fr_data[3]), 64'({8'h52, 8'h21, 8'h03, 32'h4}));
    check_eq("t4_count", 64'(o_count), 64'd4);

    // 5: abort in WAIT after 4th frame, then restart (start with abort in IDLE)
    do_start(8'd0, 8'd31, 1'b0, 8'h55);
    serve(4, 1'b0, nfr);
    check_eq("t5_frames", 64'(nfr), 64'd4);
    check_eq("t5_end", {63'd0, o_end}, 64'd1);
    check_eq("t5_aborted", {63'd0, o_aborted}, 64'd1);
    check_eq("t5_count", 64'(o_count), 64'd4);
    check_eq("t5_idle", {63'd0, o_busy}, 64'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_start_wr) bad++;
    end
    check_eq("t5_no_more_pulses", 64'(bad), 64'd0);
    i_abort = 1'b1;
    do_start(8'd0, 8'd1, 1'b0, 8'h66);
    i_abort = 1'b0;
    check_eq("t5r_busy", {63'd0, o_busy}, 64'd1);
    check_eq("t5r_end_clr", {63'd0, o_end}, 64'd0);
    check_eq("t5r_aborted_clr", {63'd0, o_aborted}, 64'd0);
    check_eq("t5r_count_clr", 64'(o_count), 64'd0);
    serve(0, 1'b0, nfr);
    check_eq("t5r_frames", 64'(nfr), 64'd2);
    check_eq("t5r_aborted", {63'd0, o_aborted}, 64'd0);

    // 6: reset in WAIT, restart with new stamp; start while busy ignored
    do_start(8'd2, 8'd31, 1'b0, 8'h11);
    tick();
    check_eq("t6_pulse", {63'd0, o_start_wr}, 64'd1);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_eq("t6_rst_busy", {63'd0, o_busy}, 64'd0);
    check_eq("t6_rst_data", 64'(o_data_wr), 64'd0);
    check_eq("t6_rst_count", 64'(o_count), 64'd0);
    check_eq("t6_rst_end", {63'd0, o_end}, 64'd0);
    do_start(8'd7, 8'd8, 1'b0, 8'h33);
    i_first = 8'd0;
    i_clk_cicle = 8'h99;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    serve(0, 1'b0, nfr);
    check_eq("t6_frames", 64'(nfr), 64'd2);
    check_eq("t6_frame0", 64'(fr_data[0]), 64'({8'h52, 8'h33, 8'h07, 32'h8}));
    check_eq("t6_frame1", 64'(fr_data[1]), 64'({8'h52, 8'h33, 8'h08, 32'h9}));
    check_eq("t6_count", 64'(o_count), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
